// File: rtl/huff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : huff_pkg
//  Description : Shared types and constants for the Huffman length sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package huff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        MERGE = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int             W_W     = 5;
    localparam logic [W_W-1:0] EMPTY_W = 5'd31;
    localparam logic [W_W-1:0] SAT_W   = 5'd30;
    localparam int             LEN_W   = 3;
    localparam int             ID_W    = 4;

endpackage
`default_nettype wire

// File: rtl/huff_len_ctrl_sort.sv
`default_nettype none
// ============================================================================
//  Module      : SORT_IP
//  Description : Combinational stable ascending sorter (odd-even transposition).
//  Revision    : 1.0 - initial release
// ============================================================================
module SORT_IP
    import huff_pkg::*;
#(
    parameter int IP_WIDTH = 8,
    parameter int OUT_N    = IP_WIDTH
) (
    input  logic [IP_WIDTH*ID_W-1:0] i_character,
    input  logic [IP_WIDTH*W_W-1:0]  i_weight,
    output logic [OUT_N*ID_W-1:0]    o_character
);

    logic [W_W-1:0]  w_key [IP_WIDTH];
    logic [ID_W-1:0] w_id  [IP_WIDTH];
    logic [W_W-1:0]  w_tmp_key;
    logic [ID_W-1:0] w_tmp_id;

    // Swapping only on strictly greater keys keeps equal keys in input order.
    always_comb begin
        w_tmp_key = '0;
        w_tmp_id  = '0;
        for (int k = 0; k < IP_WIDTH; k++) begin
            w_key[k] = i_weight[k*W_W +: W_W];
            w_id[k]  = i_character[k*ID_W +: ID_W];
        end
        for (int s = 0; s < IP_WIDTH; s++) begin
            for (int i = 0; i < IP_WIDTH - 1; i++) begin
                if (((i % 2) == (s % 2)) && (w_key[i] > w_key[i+1])) begin
                    w_tmp_key  = w_key[i];
                    w_tmp_id   = w_id[i];
                    w_key[i]   = w_key[i+1];
                    w_id[i]    = w_id[i+1];
                    w_key[i+1] = w_tmp_key;
                    w_id[i+1]  = w_tmp_id;
                end
            end
        end
    end

    generate
        for (genvar j = 0; j < OUT_N; j++) begin : g_out
            assign o_character[j*ID_W +: ID_W] = w_id[j];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/huff_len_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : huff_len_ctrl
//  Description : Loads a group of weights, merges the two lightest slots per
//                cycle and streams one Huffman code length per character.
//  Revision    : 1.0 - initial release
// ============================================================================
module huff_len_ctrl
    import huff_pkg::*;
#(
    parameter int IP_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W_W-1:0]   in_weight,
    output logic             in_ready,
    output logic             out_valid,
    output logic [LEN_W-1:0] out_len,
    output logic             out_err
);

    localparam logic [LEN_W-1:0] CNT_LAST  = LEN_W'(IP_WIDTH - 1);
    localparam logic [LEN_W-1:0] ROUND_END = LEN_W'(IP_WIDTH - 2);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LEN_W-1:0]      r_cnt;
    logic [LEN_W-1:0]      w_cnt_nxt;
    logic                  r_in_ready;
    logic                  w_in_ready_nxt;
    logic                  r_out_valid;
    logic [LEN_W-1:0]      r_out_len;
    logic                  r_out_err;
    logic                  r_err;

    logic [W_W-1:0]        r_w   [IP_WIDTH];
    logic [IP_WIDTH-1:0]   r_m   [IP_WIDTH];
    logic                  r_v   [IP_WIDTH];
    logic [LEN_W-1:0]      r_len [IP_WIDTH];

    logic [IP_WIDTH*ID_W-1:0] w_sort_char;
    logic [IP_WIDTH*W_W-1:0]  w_sort_wt;
    logic [2*ID_W-1:0]        w_sorted;
    logic [ID_W-1:0]          w_s0;
    logic [ID_W-1:0]          w_s1;
    logic [ID_W-1:0]          w_lo;
    logic [ID_W-1:0]          w_hi;
    logic [W_W-1:0]           w_w0;
    logic [W_W-1:0]           w_w1;
    logic [IP_WIDTH-1:0]      w_m0;
    logic [IP_WIDTH-1:0]      w_m1;
    logic [IP_WIDTH-1:0]      w_mrg;
    logic [W_W:0]             w_sum;
    logic                     w_ovf;
    logic [W_W-1:0]           w_sat;
    logic [LEN_W-1:0]         w_len_sel;
    logic                     w_accept;

    assign w_accept = in_valid & r_in_ready;

    generate
        for (genvar i = 0; i < IP_WIDTH; i++) begin : g_feed
            assign w_sort_char[i*ID_W +: ID_W] = ID_W'(i);
            assign w_sort_wt[i*W_W +: W_W]     = r_v[i] ? r_w[i] : EMPTY_W;
        end
    endgenerate

    SORT_IP #(
        .IP_WIDTH (IP_WIDTH),
        .OUT_N    (2)
    ) u_sort (
        .i_character (w_sort_char),
        .i_weight    (w_sort_wt),
        .o_character (w_sorted)
    );

    assign w_s0 = w_sorted[ID_W-1:0];
    assign w_s1 = w_sorted[2*ID_W-1:ID_W];
    assign w_lo = (w_s0 < w_s1) ? w_s0 : w_s1;
    assign w_hi = (w_s0 < w_s1) ? w_s1 : w_s0;

    always_comb begin
        w_w0      = '0;
        w_w1      = '0;
        w_m0      = '0;
        w_m1      = '0;
        w_len_sel = '0;
        for (int k = 0; k < IP_WIDTH; k++) begin
            if (ID_W'(k) == w_s0) begin
                w_w0 = r_w[k];
                w_m0 = r_m[k];
            end
            if (ID_W'(k) == w_s1) begin
                w_w1 = r_w[k];
                w_m1 = r_m[k];
            end
            if (LEN_W'(k) == r_cnt) begin
                w_len_sel = r_len[k];
            end
        end
    end

    // Saturating at 30 keeps 31 reserved as the empty-slot marker.
    assign w_sum = {1'b0, w_w0} + {1'b0, w_w1};
    assign w_ovf = (w_sum > {1'b0, SAT_W});
    assign w_sat = w_ovf ? SAT_W : w_sum[W_W-1:0];
    assign w_mrg = w_m0 | w_m1;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_in_ready_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt = LOAD;
                    w_cnt_nxt   = 3'd1;
                end
            end
            LOAD: begin
                w_in_ready_nxt = 1'b1;
                if (w_accept) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt    = MERGE;
                        w_cnt_nxt      = '0;
                        w_in_ready_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end
            MERGE: begin
                if (r_cnt == ROUND_END) begin
                    w_state_nxt = OUT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            OUT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_len   <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= (r_state == OUT);
            r_out_len   <= (r_state == OUT) ? w_len_sel : '0;
            r_out_err   <= (r_state == OUT) ? r_err : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
            for (int k = 0; k < IP_WIDTH; k++) begin
                r_w[k]   <= '0;
                r_m[k]   <= '0;
                r_v[k]   <= 1'b0;
                r_len[k] <= '0;
            end
        end else begin
            if ((r_state == IDLE) && w_accept) begin
                r_err <= 1'b0;
            end else if (r_state == MERGE) begin
                r_err <= r_err | w_ovf;
            end
            for (int k = 0; k < IP_WIDTH; k++) begin
                if (((r_state == IDLE) || (r_state == LOAD)) && w_accept
                        && (LEN_W'(k) == r_cnt)) begin
                    r_w[k]   <= in_weight;
                    r_m[k]   <= {{(IP_WIDTH-1){1'b0}}, 1'b1} << k;
                    r_v[k]   <= 1'b1;
                    r_len[k] <= '0;
                end else if (r_state == MERGE) begin
                    if (ID_W'(k) == w_lo) begin
                        r_w[k] <= w_sat;
                        r_m[k] <= w_mrg;
                    end
                    if (ID_W'(k) == w_hi) begin
                        r_v[k] <= 1'b0;
                    end
                    if (w_mrg[k]) begin
                        r_len[k] <= r_len[k] + 3'd1;
                    end
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_len   = r_out_len;
    assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_huff_len_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_huff_len_ctrl
//  Description : Scoreboard bench for huff_len_ctrl with a Huffman reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_huff_len_ctrl;

    localparam int N = 8;
    typedef logic [4:0] grp_t [N];

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [4:0] in_weight;
    logic       in_ready;
    logic       out_valid;
    logic [2:0] out_len;
    logic       out_err;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic [3:0] exp_q[$];
    int         first_q[$];
    bit         prev_ov  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    huff_len_ctrl #(.IP_WIDTH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_weight (in_weight),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_len   (out_len),
        .out_err   (out_err)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    endtask

    // Huffman by repeated selection of the two lightest live nodes (ties to lower index).
    function automatic void ref_push(input grp_t wt);
        int sw[N];
        int msk[N];
        bit live[N];
        int ln[N];
        bit er;
        int a, b, sum, lo, hi;
        er = 1'b0;
        for (int k = 0; k < N; k++) begin
            sw[k] = int'(wt[k]); msk[k] = 1 << k; live[k] = 1'b1; ln[k] = 0;
        end
        for (int r = 0; r < N - 1; r++) begin
            a = -1; b = -1;
            for (int k = 0; k < N; k++) begin
                if (live[k]) begin
                    if (a < 0 || sw[k] < sw[a]) begin b = a; a = k; end
                    else if (b < 0 || sw[k] < sw[b]) b = k;
                end
            end
            sum = sw[a] + sw[b];
            if (sum > 30) begin er = 1'b1; sum = 30; end
            lo = (a < b) ? a : b;
            hi = (a < b) ? b : a;
            sw[lo]   = sum;
            msk[lo]  = msk[a] | msk[b];
            live[hi] = 1'b0;
            for (int k = 0; k < N; k++) if ((msk[lo] >> k) & 1) ln[k]++;
        end
        for (int k = 0; k < N; k++) exp_q.push_back({er, 3'(ln[k])});
    endfunction

    task automatic send_group(input grp_t wt, input int gap_after, input int gap_len,
                              input bit rand_gap, input bit expect_out,
                              output int first_acc, output int last_acc);
        int tmo;
        first_acc = -1;
        last_acc  = -1;
        for (int i = 0; i < N; i++) begin
            tmo = 0;
            forever begin
                @(negedge clk);
                if (in_ready) begin
                    in_valid  = 1'b1;
                    in_weight = wt[i];
                    break;
                end
                in_valid  = 1'($urandom_range(0, 1));
                in_weight = 5'($urandom);
                tmo++;
                if (tmo > 100) begin
                    check("ready_timeout", 0, 1);
                    in_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            in_valid = 1'b0;
            if (i == gap_after) repeat (gap_len) @(posedge clk);
            if (rand_gap) repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        if (expect_out) begin
            ref_push(wt);
            first_q.push_back(last_acc + N);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] e;
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (!prev_ov) begin
                    if (first_q.size() == 0) check("unexpected_group", 1, 0);
                    else check("latency", cyc, first_q.pop_front());
                end
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("len", int'(out_len), int'(e[2:0]));
                    check("err", int'(out_err), int'(e[3]));
                end
            end else begin
                check("idle_zero", int'({out_err, out_len}), 0);
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        grp_t skew, unif, ovf, rg;
        int   f1, l1, f2, l2, t;
        skew = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd2, 5'd3, 5'd5, 5'd8};
        unif = '{default: 5'd3};
        ovf  = '{default: 5'd4};
        in_valid  = 1'b0;
        in_weight = '0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_len", int'(out_len), 0);
        check("rst_out_err", int'(out_err), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("ready_after_rst", int'(in_ready), 1);

        send_group(skew, -1, 0, 1'b0, 1'b1, f1, l1);
        send_group(unif, -1, 0, 1'b0, 1'b1, f1, l1);
        send_group(ovf,  -1, 0, 1'b0, 1'b1, f1, l1);
        send_group(skew,  3, 2, 1'b0, 1'b1, f1, l1);

        // Abort during the fourth merge round.
        send_group(unif, -1, 0, 1'b0, 1'b0, f1, l1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_ready_back", int'(in_ready), 1);
        check("abort_no_out", int'(out_valid), 0);
        send_group(unif, -1, 0, 1'b0, 1'b1, f1, l1);

        // Back-to-back: the second group is offered (with noise) throughout.
        send_group(skew, -1, 0, 1'b0, 1'b1, f1, l1);
        send_group(unif, -1, 0, 1'b0, 1'b1, f2, l2);
        check("b2b_first_accept", f2, l1 + 2 * N + 1);

        for (int g = 0; g < 12; g++) begin
            for (int k = 0; k < N; k++)
                rg[k] = 5'((g % 3 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 3));
            send_group(rg, -1, 0, 1'b1, 1'b1, f1, l1);
        end

        t = 0;
        while ((exp_q.size() > 0 || first_q.size() > 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size() + first_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
